encoder_8_to_3_seq: RTL
=======================

// Module: encoder_8_to_3_seq
// PURPOSE
//   Sequential 8-to-3 mask encoder: inverse of the 3-to-8 one-hot decoder. Captures
//   an 8-bit request mask and emits the index of every set bit, one per accepted
//   handshake, in round-robin order. Used to serialise per-slot mask vectors into
//   3-bit slot indices for downstream units.
// PARAMETERS
//   RR_ENABLE  1  1: scan starts after the last emitted index (round-robin, persists
//                 across loads); 0: scan always starts at index 0 (fixed priority)
// PORTS
//   clk          in   1  clock, all state on rising edge
//   rst          in   1  synchronous reset, active-high
//   load         in   1  capture load_mask; honoured only when load_ready=1
//   load_mask    in   8  request mask, bit i = slot i pending
//   load_ready   out  1  block idle, able to accept load
//   out_valid    out  1  out_index holds a valid pending slot
//   out_ready    in   1  consumer accepts out_index this cycle
//   out_index    out  3  encoded slot index
//   out_last     out  1  out_index is the final pending bit of this mask
//   pending      out  8  bits not yet accepted
//   done         out  1  one-cycle pulse: mask fully drained (or zero mask loaded)
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, pending=0, ptr=0, out_valid=0, out_index=0,
//     out_last=0, done=0; load_ready=1 the following cycle. Reset mid-drain aborts
//     silently: no done pulse, remaining bits discarded.
//   States: IDLE, EMIT. load_ready = (state==IDLE) && !rst.
//   IDLE: load=1, load_mask!=0 -> pending<=load_mask, out_index<=first set bit at or
//     after ptr (wrapping 7->0), out_valid<=1, state<=EMIT. Latency load->out_valid: 1.
//   IDLE: load=1, load_mask==0 -> done<=1 next cycle, stay IDLE, no out_valid.
//   EMIT: load ignored (load_ready=0). out_index, out_valid, out_last registered and
//     held stable while out_valid && !out_ready.
//   Accept (out_valid && out_ready): pending[out_index]<=0; if RR_ENABLE
//     ptr<=out_index+1 (mod 8, 3-bit wrap). If remaining pending !=0, out_index<=
//     next set bit searching from out_index+1 with wrap, out_valid stays 1: one
//     index per cycle when out_ready held high. If remaining ==0: out_valid<=0,
//     done<=1 for one cycle, state<=IDLE.
//   out_last = (popcount(pending)==1) while out_valid; 0 otherwise.
//   done is high only the cycle after the final accept (or zero-mask load); the block
//     accepts a new load in that same cycle (load_ready=1).
//   RR_ENABLE=0: ptr constant 0; emission order strictly ascending index.
//   ptr only changes on accept; never on load or idle cycles.
//   Search is a pure function of (pending, start) over 8 bits; no X on out_index.
// TESTING
//   1. Reset, load 8'b1010_0100, out_ready=1 -> out_index 2,5,7 on cycles 1,2,3;
//      out_last only with 7; done pulse cycle 4; load_ready=1 cycle 4.
//   2. RR_ENABLE=1: after test 1 (ptr=0 after 7 wraps), load 8'hFF -> 0..7; then load
//      8'h81 after accepting 3 from 8'h18 -> order 7,0.
//   3. Backpressure: load 8'h11, out_ready=0 for 5 cycles -> out_index=0, out_valid=1
//      stable, pending=8'h11; release -> 0 then 4, done.
//   4. Zero mask: load 8'h00 -> no out_valid, done=1 next cycle, pending stays 0.
//   5. Load during EMIT: load 8'h01 while draining 8'h06 -> ignored; only 1,2 emitted.
//   6. rst=1 while pending=8'hF0 mid-drain -> next cycle out_valid=0, pending=0,
//      done=0, ptr=0, load_ready=1; RR_ENABLE=0 run of 8'h81 after ptr=5 -> order 0,7.

Source files
------------

// File: rtl/encoder_8_to_3_seq_if.sv
// rtl/encoder_8_to_3_seq_if.sv - load/emit handshake bundle for the sequential mask encoder
interface encoder_8_to_3_seq_if;
  logic       load;
  logic [7:0] load_mask;
  logic       load_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic       out_last;
  logic [7:0] pending;
  logic       done;

  modport master (
    output load, load_mask, out_ready,
    input  load_ready, out_valid, out_index, out_last, pending, done
  );

  modport slave (
    input  load, load_mask, out_ready,
    output load_ready, out_valid, out_index, out_last, pending, done
  );
endinterface

// File: rtl/encoder_8_to_3_seq.sv
// rtl/encoder_8_to_3_seq.sv - serialises an 8-bit request mask into 3-bit slot indices
module encoder_8_to_3_seq #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  encoder_8_to_3_seq_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] out_index_q, out_index_d;
  logic       out_valid_q, out_valid_d;
  logic       done_q, done_d;
  logic [7:0] remaining;

  // First set bit at or after start, wrapping 7->0; 0 when the mask is empty.
  function automatic logic [2:0] find_next(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    find_next = 3'd0;
    found     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && mask[idx]) begin
        find_next = idx;
        found     = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 8'd0;
      ptr_q       <= 3'd0;
      out_index_q <= 3'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    remaining   = pending_q & ~(8'd1 << out_index_q);

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.load_mask != 8'd0) begin
            pending_d   = bus.load_mask;
            out_index_d = find_next(bus.load_mask, ptr_q);
            out_valid_d = 1'b1;
            state_d     = EMIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          pending_d = remaining;
          if (RR_ENABLE) ptr_d = out_index_q + 3'd1;
          if (remaining != 8'd0) begin
            out_index_d = find_next(remaining, out_index_q + 3'd1);
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single remaining bit <=> nonzero and clearing the lowest set bit leaves nothing.
  assign bus.out_last   = out_valid_q && (pending_q != 8'd0) &&
                          ((pending_q & (pending_q - 8'd1)) == 8'd0);
  assign bus.load_ready = (state_q == IDLE) && !rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_index  = out_index_q;
  assign bus.pending    = pending_q;
  assign bus.done       = done_q;

endmodule
